pid_ctrl: RTL

- Closed-loop motor-drive controller, directly downstream of the sensor-conditioning stage.
- Consumes the signed current error (target minus averaged current) and the not_pedaling flag.
- Produces an unsigned 12-bit drive magnitude for the PWM/commutation stage.
- Implements P + I + D. Integral and derivative history update at a decimated rate; the output is registered every clock.

---
 rtl/ebike_pkg.sv | 25 ++
 rtl/pid_integrator.sv | 48 ++++
 rtl/pid_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/ebike_pkg.sv
// Shared constants and helpers for the e-bike motor-drive control slice.
// Holds the datapath widths, decimator lengths and every saturation limit
// used by the PID controller and its integrator.
package ebike_pkg;

   localparam int ERR_W         = 13;
   localparam int DRV_W         = 12;
   localparam int INTEG_W       = 18;
   localparam int TERM_W        = 15;
   localparam int D_W           = 9;

   localparam int DEC_BITS_FAST = 15;
   localparam int DEC_BITS_SLOW = 20;

   localparam logic [INTEG_W-1:0]    INTEG_MAX = 18'h1FFFF;
   localparam logic signed [D_W-1:0] D_MIN     = -9'sd256;
   localparam logic signed [D_W-1:0] D_MAX     = 9'sd255;
   localparam logic [DRV_W-1:0]      DRV_MAX   = 12'hFFF;

   // Widen an error sample to the width of the P/I/D sum.
   function automatic logic signed [TERM_W-1:0] sext_term(input logic signed [ERR_W-1:0] e);
      return {{(TERM_W-ERR_W){e[ERR_W-1]}}, e};
   endfunction

endpackage

// File: rtl/pid_integrator.sv
// Decimated saturating accumulator for the PID I term.
// Adds the signed error into an 18-bit non-negative accumulator once per
// decimator pulse, clamping at 0 and INTEG_MAX instead of wrapping.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   dec_full    - single-cycle decimator pulse; enables one accumulation
//   clear       - synchronous clear, wins over a coincident dec_full
//   error       - signed error sample
//   integ       - accumulator value, always in 0..INTEG_MAX
module pid_integrator
   import ebike_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      dec_full,
   input  logic                      clear,
   input  logic signed [ERR_W-1:0]   error,
   output logic        [INTEG_W-1:0] integ
);

   logic signed [INTEG_W:0] sum;

   // One guard bit above the accumulator: the accumulator is never negative
   // and the error is at most 13 bits, so bit 18 is a true sign bit and
   // bit 17 set on a positive sum means the ceiling was crossed.
   always_comb begin
      sum = {1'b0, integ} + {{(INTEG_W+1-ERR_W){error[ERR_W-1]}}, error};
   end

   // Accumulate only on the decimator pulse; clear has priority so that a
   // rider who stops pedaling never leaves stale wind-up behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ <= '0;
      end else if (clear) begin
         integ <= '0;
      end else if (dec_full) begin
         if (sum[INTEG_W]) begin
            integ <= '0;
         end else if (sum[INTEG_W-1]) begin
            integ <= INTEG_MAX;
         end else begin
            integ <= sum[INTEG_W-1:0];
         end
      end
   end

endmodule

// File: rtl/pid_ctrl.sv
// Closed-loop P + I + D motor-drive controller.
// The integrator and the derivative error history advance on a decimated
// tick; the P and D terms use the live error and the drive output is
// registered every clock.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   error         - signed current error (target minus averaged current)
//   not_pedaling  - clears integrator and error history every clock while high
//   drv_mag       - unsigned 12-bit drive magnitude, clamped to 0..0xFFF
// Parameter:
//   FAST_SIM      - 1: decimator fires every 2^15 clocks, 0: every 2^20
module pid_ctrl
   import ebike_pkg::*;
#(
   parameter bit FAST_SIM = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [ERR_W-1:0]  error,
   input  logic                     not_pedaling,
   output logic        [DRV_W-1:0]  drv_mag
);

   localparam int DEC_BITS = FAST_SIM ? DEC_BITS_FAST : DEC_BITS_SLOW;

   logic [DEC_BITS_SLOW-1:0]   cnt;
   logic                       dec_full;
   logic signed [ERR_W-1:0]    hist0, hist1, hist2;
   logic [INTEG_W-1:0]         integ;
   logic signed [ERR_W:0]      d_diff;
   logic signed [D_W-1:0]      d_sat;
   logic signed [TERM_W-1:0]   p_term, i_term, d_term, sum15;

   // Free-running decimator; the all-ones low bits give a one-cycle pulse
   // per period and the counter wraps naturally at 2^20.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DEC_BITS_SLOW'(1);
      end
   end

   assign dec_full = &cnt[DEC_BITS-1:0];

   pid_integrator u_integ (
      .clk      (clk),
      .rst_n    (rst_n),
      .dec_full (dec_full),
      .clear    (not_pedaling),
      .error    (error),
      .integ    (integ)
   );

   // Three-deep decimated error history feeding the derivative term.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
      end else if (not_pedaling) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
      end else if (dec_full) begin
         hist0 <= error;
         hist1 <= hist0;
         hist2 <= hist1;
      end
   end

   // Derivative: 14 bits hold any difference of two 13-bit values, then
   // clamp to 9-bit signed. The value fits when bits 13..8 are all equal.
   always_comb begin
      d_diff = {error[ERR_W-1], error} - {hist2[ERR_W-1], hist2};
      d_sat  = d_diff[D_W-1:0];
      if (d_diff[ERR_W] && !(&d_diff[ERR_W-1:D_W-1])) begin
         d_sat = D_MIN;
      end else if (!d_diff[ERR_W] && (|d_diff[ERR_W-1:D_W-1])) begin
         d_sat = D_MAX;
      end
   end

   // Term assembly. The integrator never sets bit 17, so the shifted and
   // truncated value equals the zero-extended integ[16:4] (0..8191).
   always_comb begin
      p_term = sext_term(error);
      i_term = TERM_W'(integ >> 4);
      d_term = {{(TERM_W-D_W-1){d_sat[D_W-1]}}, d_sat, 1'b0};
      sum15  = p_term + i_term + d_term;
   end

   // Registered output clamp: negative sums give 0, anything above 12 bits
   // gives full scale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_mag <= '0;
      end else if (sum15[TERM_W-1]) begin
         drv_mag <= '0;
      end else if (|sum15[TERM_W-2:DRV_W]) begin
         drv_mag <= DRV_MAX;
      end else begin
         drv_mag <= sum15[DRV_W-1:0];
      end
   end

endmodule
